// File: rtl/alu_share_ctrl.sv
//------------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one combinational 8-bit ALU between two requesters (r0, r1).
// The block runs one operation at a time:
//   1. IDLE: accepts one operation over a valid/ready handshake.
//   2. EXEC: drives the registered operands and opcode onto the ALU.
//   3. RESP: returns the captured result and flags on the winning
//      requester's response channel.
//
// Build option:
//   ALU_SHARE_FIXED_PRIO_EN - when defined, r0 always wins a tie and no
//                             round-robin pointer exists. When undefined
//                             (default), ties alternate round-robin and r0
//                             wins the first tie after reset.
//
// Parameters:
//   CNT_W          width of the completed-response counter done_cnt
//
// Ports (K = 0, 1):
//   clk, rst       rising-edge clock, synchronous active-high reset
//   rK_valid/ready request handshake (ready is combinational, IDLE only)
//   rK_a, rK_b     operands
//   rK_op          opcode (AND OR XOR INV ADD SUB INC DEC)
//   rK_rsp_valid   result available for requester K
//   rK_rsp_ready   requester K consumes the response
//   rK_res         captured result, held until the next capture for K
//   rK_flags       captured {ovf, zero, c_out}
//   alu_a/b/op     registered ALU inputs, changing only on accept
//   alu_res/c/zero/ovf  ALU outputs, sampled at the end of EXEC
//   busy           high whenever the sequencer is not idle
//   done_cnt       number of completed response handshakes (wraps)
//------------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [7:0]       r0_a,
  input  logic [7:0]       r0_b,
  input  logic [2:0]       r0_op,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [7:0]       r0_res,
  output logic [2:0]       r0_flags,

  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [7:0]       r1_a,
  input  logic [7:0]       r1_b,
  input  logic [2:0]       r1_op,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [7:0]       r1_res,
  output logic [2:0]       r1_flags,

  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_res,
  input  logic             alu_c,
  input  logic             alu_zero,
  input  logic             alu_ovf,

  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Sequencer state and transaction ownership
  state_t           state_q;
  logic             owner_q;     // requester that owns the in-flight operation
`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic             last_q;      // owner of the most recent accept
`endif

  // Registered ALU operands
  logic [7:0]       alu_a_q;
  logic [7:0]       alu_b_q;
  logic [2:0]       alu_op_q;

  // Per-requester response registers
  logic             r0_rsp_valid_q;
  logic             r1_rsp_valid_q;
  logic [7:0]       r0_res_q;
  logic [7:0]       r1_res_q;
  logic [2:0]       r0_flags_q;
  logic [2:0]       r1_flags_q;

  logic             busy_q;
  logic [CNT_W-1:0] done_cnt_q;
  logic [CNT_W-1:0] done_cnt_d;

  // Combinational arbitration and handshake signals
  logic             prefer_r0_s;
  logic             grant0_s;
  logic             grant1_s;
  logic             accept_s;
  logic             rsp_hs_s;
  logic [7:0]       win_a_s;
  logic [7:0]       win_b_s;
  logic [2:0]       win_op_s;
  logic [2:0]       alu_flags_s;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  // On a tie, the requester that did not win last time is preferred.
  function automatic logic rr_prefers_r0(input logic last_owner);
    return (last_owner == 1'b1);
  endfunction
`endif

  // Tie-break preference: fixed (r0) or round-robin against the last owner.
  always_comb begin
    prefer_r0_s = 1'b1;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    prefer_r0_s = 1'b1;
`else
    prefer_r0_s = rr_prefers_r0(last_q);
`endif
  end

  // Grants are issued only in IDLE and are mutually exclusive by construction.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_q == ST_IDLE) begin
      grant0_s = r0_valid && (!r1_valid || prefer_r0_s);
      grant1_s = r1_valid && !grant0_s;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Select the winning requester's operands for loading into the ALU regs.
  always_comb begin
    win_a_s  = r0_a;
    win_b_s  = r0_b;
    win_op_s = r0_op;
    if (grant1_s) begin
      win_a_s  = r1_a;
      win_b_s  = r1_b;
      win_op_s = r1_op;
    end else begin
      win_a_s  = r0_a;
      win_b_s  = r0_b;
      win_op_s = r0_op;
    end
  end

  // Response handshake: only the owner's ready matters, and only in RESP.
  always_comb begin
    rsp_hs_s = 1'b0;
    if (state_q == ST_RESP) begin
      if (owner_q) begin
        rsp_hs_s = r1_rsp_ready;
      end else begin
        rsp_hs_s = r0_rsp_ready;
      end
    end else begin
      rsp_hs_s = 1'b0;
    end
  end

  assign accept_s    = grant0_s | grant1_s;
  assign done_cnt_d  = done_cnt_q + CNT_W'(1);
  assign alu_flags_s = {alu_ovf, alu_zero, alu_c};

  // Sequencer: accept -> execute -> respond, with all outputs registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      owner_q        <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_q         <= 1'b1;
`endif
      alu_a_q        <= 8'd0;
      alu_b_q        <= 8'd0;
      alu_op_q       <= 3'd0;
      r0_rsp_valid_q <= 1'b0;
      r1_rsp_valid_q <= 1'b0;
      r0_res_q       <= 8'd0;
      r1_res_q       <= 8'd0;
      r0_flags_q     <= 3'd0;
      r1_flags_q     <= 3'd0;
      busy_q         <= 1'b0;
      done_cnt_q     <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q  <= ST_EXEC;
            busy_q   <= 1'b1;
            owner_q  <= grant1_s;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_q   <= grant1_s;
`endif
            alu_a_q  <= win_a_s;
            alu_b_q  <= win_b_s;
            alu_op_q <= win_op_s;
          end
        end

        ST_EXEC: begin
          // ALU inputs have been stable for a full cycle; capture for the owner only.
          state_q <= ST_RESP;
          if (owner_q) begin
            r1_res_q       <= alu_res;
            r1_flags_q     <= alu_flags_s;
            r1_rsp_valid_q <= 1'b1;
          end else begin
            r0_res_q       <= alu_res;
            r0_flags_q     <= alu_flags_s;
            r0_rsp_valid_q <= 1'b1;
          end
        end

        ST_RESP: begin
          // Returning to IDLE here means a waiting request is accepted next cycle.
          if (rsp_hs_s) begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            r0_rsp_valid_q <= 1'b0;
            r1_rsp_valid_q <= 1'b0;
            done_cnt_q     <= done_cnt_d;
          end
        end

        default: begin
          state_q        <= ST_IDLE;
          busy_q         <= 1'b0;
          r0_rsp_valid_q <= 1'b0;
          r1_rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign r0_ready     = grant0_s;
  assign r1_ready     = grant1_s;
  assign r0_rsp_valid = r0_rsp_valid_q;
  assign r1_rsp_valid = r1_rsp_valid_q;
  assign r0_res       = r0_res_q;
  assign r1_res       = r1_res_q;
  assign r0_flags     = r0_flags_q;
  assign r1_flags     = r1_flags_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign busy         = busy_q;
  assign done_cnt     = done_cnt_q;

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-port arbiter and sequencer that shares the single combinational 8-bit ALU between two requesters, such as the instruction datapath and a DMA/debug port. It accepts one operation at a time over a valid/ready handshake and registers the operands and opcode onto the ALU inputs. It captures the result and flags one cycle later and returns them on the winning requester's response channel. It sits directly in front of the ALU. No other block drives ALU inputs.

## Interface
Parameters:
- CNT_W, 16, width of completed-operation counter `done_cnt`.

Ports (`K` = 0, 1; each `rK_*` line exists once per requester):
- `clk` in 1 — rising-edge clock.
- `rst` in 1 — reset, synchronous, active-high.
- `rK_valid` in 1 — requester K has an operation pending.
- `rK_ready` out 1 — requester K's operation is accepted this cycle when `rK_valid` is also high.
- `rK_a` in 8 — operand A.
- `rK_b` in 8 — operand B.
- `rK_op` in 3 — ALU opcode (000 AND, 001 OR, 010 XOR, 011 INV, 100 ADD, 101 SUB, 110 INC, 111 DEC).
- `rK_rsp_valid` out 1 — result available for requester K.
- `rK_rsp_ready` in 1 — requester K consumes the response.
- `rK_res` out 8 — captured result.
- `rK_flags` out 3 — captured `{ovf, zero, c_out}`.
- `alu_a` out 8 — registered ALU operand A.
- `alu_b` out 8 — registered ALU operand B.
- `alu_op` out 3 — registered ALU opcode.
- `alu_res` in 8 — ALU result.
- `alu_c` in 1 — ALU carry out.
- `alu_zero` in 1 — ALU zero flag.
- `alu_ovf` in 1 — ALU overflow flag.
- `busy` out 1 — high whenever the FSM is not in IDLE.
- `done_cnt` out CNT_W — count of responses handed off.

## Operation
- FSM states:
  - IDLE to EXEC on accept.
  - EXEC to RESP unconditionally.
  - RESP to IDLE when `rK_rsp_ready` is high for the owning requester.
- Arbitration happens only in IDLE. `rK_ready` is combinational: `(state==IDLE) && grant_K`.
  - `grant_K` is high only when `rK_valid` is high.
  - At most one `rK_ready` is high per cycle.
- Round-robin:
  - The `last` pointer records the owner of the most recent accept.
  - If both requesters are valid, the one that is not `last` wins.
  - Reset sets `last=1`, so r0 wins the first tie.
- On accept:
  - `alu_a`, `alu_b` and `alu_op` load from the winner.
  - `owner` is set to K and `last` is set to K.
- EXEC:
  - `alu_*` are held stable.
  - At the end of the cycle, `alu_res` is captured to the owner's `rK_res`, and `{alu_ovf, alu_zero, alu_c}` is captured to the owner's `rK_flags`.
- RESP:
  - Only the owner's `rK_rsp_valid` is high.
  - Response data is stable until the handshake completes.
  - No new request is accepted in RESP.
- `rK_res` and `rK_flags` hold their last captured value after the handshake. The other requester's outputs are never disturbed.
- `alu_*` hold their last value in IDLE. They change only on accept.
- `done_cnt` increments on each response handshake and wraps from all-ones to 0.
- Requesters must hold `rK_valid` and their operands until `rK_ready`. A requester that drops `rK_valid` before acceptance loses its turn, with no side effect.

## Timing
- Reset values:
  - state IDLE, `last=1`.
  - All `rK_ready` and `rK_rsp_valid` = 0.
  - `rK_res` = 0, `rK_flags` = 0.
  - `alu_a`, `alu_b`, `alu_op` = 0.
  - `busy` = 0, `done_cnt` = 0.
- Latency: accept at edge N, so `rK_rsp_valid` is high from edge N+2.
- Minimum issue interval is 3 cycles: accept, EXEC, RESP with immediate `rsp_ready`. The next accept is possible at N+3.
- `rsp_ready` held high early has no effect until RESP.
- `rst` asserted in any state:
  - Any in-flight operation is dropped with no response.
  - All outputs return to reset values at the next edge.
  - `done_cnt` does not count the dropped operation.
- If `rK_valid` and `rK_rsp_ready` for the same K are both high in RESP, the handshake completes. Acceptance of the new request then occurs in the following IDLE cycle, never in the same cycle.

## Configuration
- `ALU_SHARE_FIXED_PRIO_EN` defined:
  - Fixed priority; r0 always wins ties.
  - The `last` pointer is not implemented.
- Undefined (default): round-robin as described in Operation.
- All other behaviour is identical in both builds.

## Test plan
- **Single op:** after reset, r0 requests ADD a=0x7F b=0x01. Bench ALU model returns 0x80, c=0, zero=0, ovf=1.
  - Required: `r0_ready` high at cycle 0, `alu_a`=0x7F and `alu_op`=100 at cycle 1, `r0_rsp_valid` at cycle 2, `r0_res`=0x80, `r0_flags`=3'b100, `done_cnt`=1.
- **Tie, round-robin build:** both valid continuously with distinct ops.
  - Required: grants r0, r1, r0, r1. Each response goes only to its owner. `r1_res` is unchanged during r0's transactions.
- **Tie, `ALU_SHARE_FIXED_PRIO_EN` build:** both valid continuously.
  - Required: r0 is granted every time; r1 is never granted while `r0_valid` is held.
- **Backpressure:** `r0_rsp_ready`=0 for 5 cycles while `r1_valid`=1.
  - Required: `busy`=1, `r1_ready`=0 throughout, `r0_res` stable. After ready, r1 is accepted one cycle after the handshake.
- **Reset in EXEC:** `rst` asserted during the EXEC cycle.
  - Required: no `rsp_valid`, `alu_*`=0, `done_cnt` unchanged at 0, `last`=1 (next tie goes to r0).
- **Counter wrap:** with CNT_W=4, run 16 ops.
  - Required: `done_cnt` reads 0xF after the 15th op and 0x0 after the 16th.
